// File: rtl/pe_output_arbiter.sv
// pe_output_arbiter
// Shares one NI injection port among NUM_PE processing elements. A rotating
// priority pointer picks one valid PE per cycle, and its flit is captured in a
// single output register that can refill in the same cycle it drains. Every PE
// that is not picked sees ready low, which stalls its pipeline.

module pe_output_arbiter #(
  parameter int NUM_PE      = 4,
  parameter int PACKET_SIZE = 32,
  parameter int GNT_W       = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PE-1:0]             PE_ARB_valid,
  input  logic [NUM_PE*PACKET_SIZE-1:0] PE_ARB_packet,
  output logic [NUM_PE-1:0]             PE_ARB_ready,
  input  logic                          NI_ready,
  output logic                          ARB_NI_valid,
  output logic [PACKET_SIZE-1:0]        ARB_NI_packet,
  output logic [GNT_W-1:0]              ARB_grant
);

  localparam logic [GNT_W-1:0] LAST_IDX = GNT_W'(NUM_PE - 1);

  logic [GNT_W-1:0]       ptr_q, ptr_d;
  logic [GNT_W-1:0]       grant_q, grant_d;
  logic                   valid_q, valid_d;
  logic [PACKET_SIZE-1:0] packet_q, packet_d;

  logic [GNT_W-1:0]       winner;
  logic [GNT_W-1:0]       hi_idx, lo_idx;
  logic                   found_hi;
  logic                   any_valid;
  logic                   accept;
  logic                   pe_xfer;
  logic [PACKET_SIZE-1:0] sel_packet;

  // Cyclic search from ptr: lowest valid index at or above ptr wins; otherwise
  // wrap around to the lowest valid index overall.
  always_comb begin
    found_hi  = 1'b0;
    any_valid = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      if (PE_ARB_valid[i]) begin
        any_valid = 1'b1;
        lo_idx    = GNT_W'(i);
        if (GNT_W'(i) >= ptr_q) begin
          found_hi = 1'b1;
          hi_idx   = GNT_W'(i);
        end
      end
    end
    winner = found_hi ? hi_idx : lo_idx;
  end

  // Handshake: the output stage can take a flit when empty or draining, and
  // only the winner sees ready; reset forces every ready low.
  always_comb begin
    accept       = !valid_q || NI_ready;
    pe_xfer      = rst && any_valid && accept;
    PE_ARB_ready = '0;
    sel_packet   = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (winner == GNT_W'(i)) begin
        PE_ARB_ready[i] = pe_xfer;
        sel_packet      = PE_ARB_packet[i*PACKET_SIZE +: PACKET_SIZE];
      end
    end
  end

  // Output-stage and pointer next state: load on a PE transfer, clear valid on
  // a drain with no refill, otherwise hold (including NI stall).
  always_comb begin
    valid_d  = valid_q;
    packet_d = packet_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    if (pe_xfer) begin
      valid_d  = 1'b1;
      packet_d = sel_packet;
      grant_d  = winner;
      ptr_d    = (winner == LAST_IDX) ? '0 : winner + GNT_W'(1);
    end else if (valid_q && NI_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset; a held flit is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      packet_q <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      packet_q <= packet_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
    end
  end

  assign ARB_NI_valid  = valid_q;
  assign ARB_NI_packet = packet_q;
  assign ARB_grant     = grant_q;

endmodule

// File: doc/pe_output_arbiter.md
# pe_output_arbiter

Round-robin arbiter that shares one network-interface injection port among `NUM_PE` processing elements. Each PE presents single-flit packets on a valid/ready pair; the arbiter selects one requester per cycle, registers the packet into a one-entry output stage toward the NI, and back-pressures all losers. The PE-side ready drives each PE's `PE_NI_ready`, so a PE that is not granted halts its pipeline.

## Interface
- `NUM_PE`, 4: number of PE requesters; legal range is 1–16.
- `PACKET_SIZE`, 32: flit width in bits.
- `GNT_W`, `max(1,$clog2(NUM_PE))`: width of the grant index.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `PE_ARB_valid`  in  NUM_PE  per-PE packet valid.
- `PE_ARB_packet`  in  NUM_PE*PACKET_SIZE  per-PE packets; PE *i* occupies bits [i*PACKET_SIZE +: PACKET_SIZE].
- `PE_ARB_ready`  out  NUM_PE  per-PE ready; one-hot or zero.
- `NI_ready`  in  1  NI accepts the output flit this cycle.
- `ARB_NI_valid`  out  1  output flit valid (registered).
- `ARB_NI_packet`  out  PACKET_SIZE  output flit (registered).
- `ARB_grant`  out  GNT_W  index of the PE whose flit is in the output register (registered).

## Operation
- **Transfer rules.**
  - A PE transfer occurs when `PE_ARB_valid[i] && PE_ARB_ready[i]`.
  - An NI transfer occurs when `ARB_NI_valid && NI_ready`.
- **Accept condition.** `accept = !ARB_NI_valid || NI_ready`. The output register is empty or drains this cycle.
- **Priority pointer.** `ptr` (GNT_W bits) is registered.
  - The winner is the first index with `PE_ARB_valid` set, searching cyclically from `ptr` through `ptr+NUM_PE-1` (mod NUM_PE).
- **Ready generation.** `PE_ARB_ready[winner] = accept`. All other ready bits are 0.
  - Ready is combinational from `PE_ARB_valid`, `NI_ready` and state. PEs must drive `valid` from a register.
- **On a PE transfer:**
  - `ARB_NI_packet <= packet[winner]`
  - `ARB_NI_valid <= 1`
  - `ARB_grant <= winner`
  - `ptr <= (winner+1) mod NUM_PE`
- **Drain without refill.** If `accept` holds and there is no PE transfer while `ARB_NI_valid` is 1 and `NI_ready` is 1, then `ARB_NI_valid <= 0`. `ARB_NI_packet` and `ARB_grant` hold their values.
- **Stall.** If `ARB_NI_valid` is 1 and `NI_ready` is 0, the output register holds, all `PE_ARB_ready` bits are 0, and `ptr` holds.
- **Pointer update.** `ptr` changes only on a PE transfer; idle cycles do not advance it.
- **Fairness.** A continuously requesting PE waits at most `NUM_PE-1` grants to other PEs.
- **NUM_PE = 1.** `ptr` and `ARB_grant` are constant 0. The block degenerates to a one-entry pipeline register.
- **Packet contents.** The payload is never inspected or modified.

## Timing
- **Reset values** (rst = 0 at an edge):
  - `ARB_NI_valid = 0`
  - `ARB_NI_packet = 0`
  - `ARB_grant = 0`
  - `ptr = 0`
  - `PE_ARB_ready = 0` while rst is low.
- **Latency.** Fixed at 1 cycle: a flit accepted from a PE at edge *n* is presented on `ARB_NI_*` from edge *n*.
- **Throughput.** 1 flit per cycle with `NI_ready` held at 1. The output stage accepts a new flit in the same cycle the old one leaves.
- **Simultaneous events.** An NI drain and a PE refill in the same cycle leave `ARB_NI_valid` at 1 and load the new flit.
- **NI ready deasserted.** No PE transfer occurs. The current flit stays stable until the NI accepts it (AXI-style hold).
- **Reset mid-operation.** A flit in the output register is discarded with no NI transfer. The pointer restarts at PE 0.
- **PE withdrawing valid.** A PE that deasserts `valid` before being granted loses nothing. The arbiter tolerates valid withdrawal without hazard.

## Test plan
- **Reset.** Hold `rst` = 0 for 3 cycles with all `PE_ARB_valid` = 4'b1111 → `ARB_NI_valid` = 0, `PE_ARB_ready` = 0 and `ARB_grant` = 0 throughout. On the first cycle after release, `PE_ARB_ready` = 4'b0001.
- **Full contention.** NUM_PE = 4, all PEs valid continuously with packets 0xA0..0xA3, `NI_ready` = 1 → the output sequence is A0, A1, A2, A3, A0, …, one flit per cycle. `ARB_grant` cycles 0, 1, 2, 3.
- **Sparse requesters.** Only PEs 1 and 3 valid, `ptr` = 0 → grants alternate 1, 3, 1, 3. PEs 0 and 2 never see ready.
- **Back-pressure.** Hold `NI_ready` = 0 for 5 cycles after the flit from PE 2 is loaded → `ARB_NI_packet` stays stable and all ready bits stay 0. When `NI_ready` returns, PE 3 is granted in the same cycle, and the output holds PE 3's flit on the next edge.
- **Drain, then idle.** A single flit from PE 0 with `NI_ready` = 1, then no requests → `ARB_NI_valid` is 1 for exactly one cycle, then 0. `ptr` = 1, and the next request from PE 0 and PE 1 together grants PE 1 first.
- **Reset mid-stall.** Assert `rst` while `ARB_NI_valid` = 1 and `NI_ready` = 0 → next cycle `ARB_NI_valid` = 0 and `ARB_NI_packet` = 0. After release, the first grant goes to the lowest-indexed valid PE.
